// File: rtl/idu_lsiq_pkg.sv
// Shared LSIQ sizing constants and pointer helpers used by the entry array and
// the LSIQ controller.
package idu_lsiq_pkg;

   localparam int LSIQ_DEPTH  = 8;
   localparam int LSIQ_PTR_W  = 3;
   localparam int LSIQ_WAIT_W = 8;

   function automatic logic [LSIQ_DEPTH-1:0] lsiq_ptr2onehot(input logic [LSIQ_PTR_W-1:0] ptr);
      logic [LSIQ_DEPTH-1:0] onehot;
      onehot      = '0;
      onehot[ptr] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/idu_is_lsiq_ptr.sv
// Wrapping circular pointer for the LSIQ; flush has priority over advance.
module idu_is_lsiq_ptr
   import idu_lsiq_pkg::*;
#(
   parameter int PTR_W = LSIQ_PTR_W
) (
   input  logic             clk,
   input  logic             rst_clk,
   input  logic             flush,
   input  logic             advance,
   output logic [PTR_W-1:0] ptr
);

   // DEPTH is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk)
         ptr <= '0;
      else if (flush)
         ptr <= '0;
      else if (advance)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/idu_is_lsiq_ctrl.sv
// In-order LSIQ scheduler: circular allocation, oldest-first issue, occupancy,
// flush recovery, head-stall monitor and sticky consistency error.
module idu_is_lsiq_ctrl
   import idu_lsiq_pkg::*;
#(
   parameter int DEPTH  = LSIQ_DEPTH,
   parameter int PTR_W  = LSIQ_PTR_W,
   parameter int WAIT_W = LSIQ_WAIT_W
) (
   input  logic              clk,
   input  logic              rst_clk,
   input  logic              rtu_global_flush,
   input  logic              dp_lsiq_create_vld,
   output logic              lsiq_dp_full,
   output logic              lsiq_dp_empty,
   output logic [PTR_W:0]    lsiq_entry_cnt,
   output logic [DEPTH-1:0]  lsiq_create_sel,
   input  logic [DEPTH-1:0]  entry_vld,
   input  logic [DEPTH-1:0]  entry_ready,
   input  logic              lsu_idu_ready,
   output logic              lsiq_issue_vld,
   output logic [DEPTH-1:0]  lsiq_issue_sel,
   output logic [WAIT_W-1:0] lsiq_head_wait,
   output logic              lsiq_err
);

   logic [PTR_W-1:0]  create_ptr;
   logic [PTR_W-1:0]  issue_ptr;
   logic [PTR_W:0]    cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              err;
   logic              full;
   logic              empty;
   logic              create_fire;
   logic              issue_fire;
   logic              err_detect;

   function automatic logic [PTR_W:0] vld_popcnt(input logic [DEPTH-1:0] v);
      logic [PTR_W:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++)
         c = c + {{PTR_W{1'b0}}, v[i]};
      return c;
   endfunction

   assign full  = (cnt == (PTR_W+1)'(DEPTH));
   assign empty = (cnt == '0);

   // A create while full is dropped even if the head issues this cycle
   assign create_fire = dp_lsiq_create_vld & ~full & ~rtu_global_flush;
   assign issue_fire  = ~empty & entry_vld[issue_ptr] & entry_ready[issue_ptr]
                        & lsu_idu_ready & ~rtu_global_flush;

   assign err_detect = (~empty & ~entry_vld[issue_ptr]) | (vld_popcnt(entry_vld) != cnt);

   idu_is_lsiq_ptr #(.PTR_W(PTR_W)) u_create_ptr (
      .clk     (clk),
      .rst_clk (rst_clk),
      .flush   (rtu_global_flush),
      .advance (create_fire),
      .ptr     (create_ptr)
   );

   idu_is_lsiq_ptr #(.PTR_W(PTR_W)) u_issue_ptr (
      .clk     (clk),
      .rst_clk (rst_clk),
      .flush   (rtu_global_flush),
      .advance (issue_fire),
      .ptr     (issue_ptr)
   );

   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         cnt      <= '0;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (rtu_global_flush)
            cnt <= '0;
         else if (create_fire & ~issue_fire)
            cnt <= cnt + 1'b1;
         else if (issue_fire & ~create_fire)
            cnt <= cnt - 1'b1;

         if (rtu_global_flush | issue_fire)
            wait_cnt <= '0;
         else if (~empty) begin
            if (wait_cnt != '1)
               wait_cnt <= wait_cnt + 1'b1;
         end else
            wait_cnt <= '0;

         // Sticky until reset; flush deliberately leaves it set
         if (err_detect)
            err <= 1'b1;
      end
   end

   assign lsiq_dp_full    = full;
   assign lsiq_dp_empty   = empty;
   assign lsiq_entry_cnt  = cnt;
   assign lsiq_create_sel = create_fire ? lsiq_ptr2onehot(create_ptr) : '0;
   assign lsiq_issue_vld  = issue_fire;
   assign lsiq_issue_sel  = issue_fire ? lsiq_ptr2onehot(issue_ptr) : '0;
   assign lsiq_head_wait  = wait_cnt;
   assign lsiq_err        = err;

endmodule

// File: tb/tb_idu_is_lsiq_ctrl.sv
// Directed bench for idu_is_lsiq_ctrl with a behavioural entry-valid array and
// strobe scoreboard queues.
module tb_idu_is_lsiq_ctrl;
   import idu_lsiq_pkg::*;

   localparam int D  = 8;
   localparam int PW = 3;
   localparam int WW = 8;

   logic          clk = 1'b0;
   logic          rst_clk = 1'b0;
   logic          flush = 1'b0;
   logic          cvld = 1'b0;
   logic          lsu_rdy = 1'b0;
   logic [D-1:0]  ent_rdy = '0;
   logic [D-1:0]  vld_mask = '0;
   logic [D-1:0]  ent_vld;
   logic [D-1:0]  entry_vld;
   logic          full, empty, issue_vld, err;
   logic [PW:0]   cnt;
   logic [D-1:0]  create_sel, issue_sel;
   logic [WW-1:0] head_wait;

   int checks = 0;
   int errors = 0;
   logic [D-1:0] exp_cs_q[$];
   logic [D-1:0] exp_is_q[$];

   always #5 clk = ~clk;

   idu_is_lsiq_ctrl dut (
      .clk                (clk),
      .rst_clk            (rst_clk),
      .rtu_global_flush   (flush),
      .dp_lsiq_create_vld (cvld),
      .lsiq_dp_full       (full),
      .lsiq_dp_empty      (empty),
      .lsiq_entry_cnt     (cnt),
      .lsiq_create_sel    (create_sel),
      .entry_vld          (entry_vld),
      .entry_ready        (ent_rdy),
      .lsu_idu_ready      (lsu_rdy),
      .lsiq_issue_vld     (issue_vld),
      .lsiq_issue_sel     (issue_sel),
      .lsiq_head_wait     (head_wait),
      .lsiq_err           (err)
   );

   // Behavioural entry array: set by create strobe, cleared by issue strobe or flush
   always @(posedge clk or negedge rst_clk) begin
      if (!rst_clk)
         ent_vld <= '0;
      else if (flush)
         ent_vld <= '0;
      else
         ent_vld <= (ent_vld | create_sel) & ~issue_sel;
   end
   assign entry_vld = ent_vld & ~vld_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, queue expected strobes, compare mid-cycle, advance
   task automatic cyc(input logic c, input logic l, input logic [D-1:0] r, input logic f,
                      input logic [D-1:0] exp_cs, input logic [D-1:0] exp_is);
      logic [D-1:0] e;
      cvld    = c;
      lsu_rdy = l;
      ent_rdy = r;
      flush   = f;
      exp_cs_q.push_back(exp_cs);
      exp_is_q.push_back(exp_is);
      @(negedge clk);
      e = exp_cs_q.pop_front();
      chk("create_sel", 32'(create_sel), 32'(e));
      e = exp_is_q.pop_front();
      chk("issue_sel", 32'(issue_sel), 32'(e));
      chk("issue_vld", 32'(issue_vld), 32'(|e));
      @(posedge clk);
      #1;
      cvld  = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_create_sel", 32'(create_sel), 32'd0);
      chk("rst_issue_vld", 32'(issue_vld), 32'd0);
      chk("rst_head_wait", 32'(head_wait), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      #10 rst_clk = 1'b1;
      @(posedge clk);
      #1;

      // Fill all eight entries in order
      for (int i = 0; i < D; i++) begin
         logic [D-1:0] oh;
         oh = '0;
         oh[i] = 1'b1;
         cyc(1'b1, 1'b0, '0, 1'b0, oh, '0);
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_cnt", 32'(cnt), 32'd8);
      cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
      chk("create_when_full_cnt", 32'(cnt), 32'd8);
      chk("fill_err", 32'(err), 32'd0);

      // Full queue: issue head while create is ignored, then wrap create
      cyc(1'b1, 1'b1, 8'hFF, 1'b0, '0, 8'h01);
      chk("post_issue_cnt", 32'(cnt), 32'd7);
      chk("post_issue_full", 32'(full), 32'd0);
      chk("post_issue_wait", 32'(head_wait), 32'd0);
      cyc(1'b1, 1'b0, 8'hFF, 1'b0, 8'h01, '0);
      chk("wrap_cnt", 32'(cnt), 32'd8);

      // Flush, then three entries with a non-ready head
      cyc(1'b0, 1'b0, '0, 1'b1, '0, '0);
      chk("flush1_empty", 32'(empty), 32'd1);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h01, '0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h02, '0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h04, '0);
      chk("three_wait", 32'(head_wait), 32'd2);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 8'h06, 1'b0, '0, '0);
         chk("inorder_wait", 32'(head_wait), 32'(3 + i));
      end
      cyc(1'b0, 1'b1, 8'h07, 1'b0, '0, 8'h01);
      chk("inorder_wait_clr", 32'(head_wait), 32'd0);
      chk("inorder_cnt", 32'(cnt), 32'd2);

      // LSU back-pressure: wait counter saturates
      for (int i = 0; i < 300; i++)
         cyc(1'b0, 1'b0, 8'hFF, 1'b0, '0, '0);
      chk("sat_wait", 32'(head_wait), 32'd255);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0, '0, 8'h02);
      chk("sat_wait_clr", 32'(head_wait), 32'd0);
      chk("sat_cnt", 32'(cnt), 32'd1);

      // Grow to five, then simultaneous create and issue
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h08, '0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h10, '0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h20, '0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h40, '0);
      chk("five_cnt", 32'(cnt), 32'd5);
      cyc(1'b1, 1'b1, 8'hFF, 1'b0, 8'h80, 8'h04);
      chk("both_cnt_a", 32'(cnt), 32'd5);
      cyc(1'b1, 1'b1, 8'hFF, 1'b0, 8'h01, 8'h08);
      chk("both_cnt_b", 32'(cnt), 32'd5);

      // Flush suppresses both strobes and clears state
      cyc(1'b1, 1'b1, 8'hFF, 1'b1, '0, '0);
      chk("flush_cnt", 32'(cnt), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_wait", 32'(head_wait), 32'd0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h01, '0);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0, '0, 8'h01);
      chk("flush_ptr_cnt", 32'(cnt), 32'd0);

      // Consistency error: head valid bit dropped
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h02, '0);
      cyc(1'b1, 1'b0, '0, 1'b0, 8'h04, '0);
      chk("pre_err", 32'(err), 32'd0);
      vld_mask = 8'h02;
      cyc(1'b0, 1'b0, '0, 1'b0, '0, '0);
      vld_mask = '0;
      chk("err_set", 32'(err), 32'd1);
      cyc(1'b0, 1'b0, '0, 1'b1, '0, '0);
      chk("err_sticky_flush", 32'(err), 32'd1);
      rst_clk = 1'b0;
      #2;
      chk("err_reset", 32'(err), 32'd0);
      chk("reset_mid_cnt", 32'(cnt), 32'd0);
      chk("reset_mid_empty", 32'(empty), 32'd1);
      rst_clk = 1'b1;
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idu_is_lsiq_ctrl.md
Name: idu_is_lsiq_ctrl

Overview:
In-order scheduler for the load/store issue queue (LSIQ) entry array. It allocates entries to dispatched memory ops in a circular FIFO order and issues the oldest entry to the LSU once its operands are ready and the LSU can accept. It also owns full/empty/occupancy reporting to dispatch, global-flush recovery, a head-stall monitor and a consistency-error flag.

Parameters:
DEPTH, 8, number of LSIQ entries (power of two, >=2)
PTR_W, 3, log2(DEPTH)
WAIT_W, 8, width of head-stall saturating counter

Ports:
clk  in  1  clock
rst_clk  in  1  reset, asynchronous, active-low
rtu_global_flush  in  1  discard all LSIQ contents
dp_lsiq_create_vld  in  1  dispatch presents one memory op this cycle
lsiq_dp_full  out  1  no free entry; dispatch must hold
lsiq_dp_empty  out  1  no valid entry
lsiq_entry_cnt  out  PTR_W+1  occupied-entry count
lsiq_create_sel  out  DEPTH  one-hot create strobe to entries (entry create_vld)
entry_vld  in  DEPTH  per-entry vld from the entry array
entry_ready  in  DEPTH  per-entry ready (both sources ready and vld)
lsu_idu_ready  in  1  LSU accepts an op this cycle
lsiq_issue_vld  out  1  op issued to LSU this cycle
lsiq_issue_sel  out  DEPTH  one-hot issue strobe to entries and the read mux
lsiq_head_wait  out  WAIT_W  cycles the head has been valid but not issued (saturating)
lsiq_err  out  1  sticky occupancy/entry_vld mismatch

Behaviour:
- State: create_ptr, issue_ptr (PTR_W bits, wrap DEPTH-1 -> 0), cnt (PTR_W+1 bits), wait_cnt, err. Reset: all zero, so after reset lsiq_dp_empty=1, lsiq_dp_full=0, cnt=0, all other outputs 0.
- full = (cnt == DEPTH); empty = (cnt == 0); both combinational from registered cnt.
- create_fire = dp_lsiq_create_vld & !full & !rtu_global_flush. lsiq_create_sel = onehot(create_ptr) when create_fire, else 0. A create while full is ignored (no same-cycle refill from a simultaneous issue); dispatch retries.
- issue_fire = !empty & entry_vld[issue_ptr] & entry_ready[issue_ptr] & lsu_idu_ready & !rtu_global_flush. lsiq_issue_vld = issue_fire; lsiq_issue_sel = onehot(issue_ptr) when issue_fire, else 0. Issue is combinational in the same cycle; the entry clears at the next edge. Strictly in order: younger ready entries never bypass a non-ready head.
- Next state: create_fire advances create_ptr; issue_fire advances issue_ptr. cnt +1 on create only, -1 on issue only, unchanged on both.
- Create and issue never target the same slot: equal pointers imply empty (no issue) or full (no create).
- Flush: at the next edge create_ptr=issue_ptr=cnt=wait_cnt=0. Flush-cycle strobes are forced to 0. err is not cleared.
- wait_cnt: 0 on flush or issue_fire; +1 (saturate at all-ones) when !empty and no issue_fire; else 0.
- err: set to 1 when !empty & !entry_vld[issue_ptr], or when the popcount of entry_vld != cnt. Cleared only by reset.
- Asynchronous reset mid-operation returns to the reset state immediately. The entry array resets in the same event.

Decomposition:
- Shared package idu_lsiq_pkg: LSIQ_DEPTH, LSIQ_PTR_W, LSIQ_WAIT_W constants and a ptr-to-one-hot function. The entry array and this controller share them.
- One sub-module, idu_is_lsiq_ptr: a wrapping PTR_W pointer with advance and flush-clear inputs. It is instantiated twice (create and issue).

Test Plan:
- After reset, 8 consecutive create_vld with entry_vld mirroring the creates: create_sel = 0x01, 0x02, …, 0x80. After the 8th, full=1 and cnt=8. A 9th create_vld gives create_sel=0 and cnt stays 8.
- Full queue, head entry 0 ready, lsu_idu_ready=1, create_vld=1 in the same cycle: issue_sel=0x01 and create_sel=0. Next cycle cnt=7, full=0, and a create gives create_sel=0x01 (wrap).
- Entries 0..2 valid, entry_ready=0b110, lsu ready: no issue (in-order). wait_cnt counts 1, 2, 3… Setting entry_ready[0]=1 gives issue_sel=0x01, and wait_cnt is 0 the next cycle.
- Head ready but lsu_idu_ready=0 for 300 cycles: issue_vld=0 and wait_cnt saturates at 255. LSU ready then gives one issue.
- cnt=5 with simultaneous create and issue: cnt stays 5 and both pointers advance. Then rtu_global_flush with create_vld and a ready head: both strobes=0. Next cycle cnt=0, empty=1, pointers 0.
- cnt=2 with entry_vld forced to 0 at issue_ptr: err=1 next cycle and stays 1 through a flush. Reset clears it.
